ahb_master_port: RTL

AHB_MASTER_PORT -- requirements
Module: ahb_master_port

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_master_port_if.sv | 40 ++++
 rtl/ahb_master_port.sv | 91 +++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings (HTRANS, HRESP, HSIZE, HBURST) and master FSM state constants.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;
    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    typedef logic [2:0] mst_state_t;
    localparam mst_state_t ST_IDLE  = 3'd0;
    localparam mst_state_t ST_REQ   = 3'd1;
    localparam mst_state_t ST_ADDR  = 3'd2;
    localparam mst_state_t ST_DATA  = 3'd3;
    localparam mst_state_t ST_RESP2 = 3'd4;
endpackage

// File: rtl/ahb_master_port_if.sv
// ahb_master_port_if: local command handshake plus AHB master bus signals, with master and slave views.
interface ahb_master_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_lock;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_size;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              HBUSREQ;
    logic              HLOCK;
    logic              HGRANT;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    modport master (
        input  req_valid, req_write, req_lock, req_addr, req_wdata, req_size,
        input  HGRANT, HREADY, HRESP, HRDATA,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output HBUSREQ, HLOCK, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
    modport slave (
        output req_valid, req_write, req_lock, req_addr, req_wdata, req_size,
        output HGRANT, HREADY, HRESP, HRDATA,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  HBUSREQ, HLOCK, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahb_master_port.sv
// ahb_master_port: single-transfer AHB master with RETRY/SPLIT re-issue and error completion.
// Optional AHB_MASTER_LOCK_EN drives HLOCK from the captured req_lock; otherwise HLOCK is 0.
module ahb_master_port
    import ahb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 8
) (
    input logic HCLK,
    input logic HRESET,
    ahb_master_port_if.master bus
);
    localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RETRY);
    mst_state_t        state;
    logic              write_q;
    logic              lock_q;
    logic              lock_in;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        size_q;
    logic [CW-1:0]     retry_cnt;
`ifdef AHB_MASTER_LOCK_EN
    assign lock_in = bus.req_lock;
`else
    assign lock_in = 1'b0;
`endif
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state          <= ST_IDLE;
            write_q        <= 1'b0;
            lock_q         <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            size_q         <= '0;
            retry_cnt      <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    write_q   <= bus.req_write;
                    lock_q    <= lock_in;
                    addr_q    <= bus.req_addr;
                    wdata_q   <= bus.req_wdata;
                    size_q    <= bus.req_size;
                    retry_cnt <= '0;
                    state     <= ST_REQ;
                end
                ST_REQ:  if (bus.HGRANT && bus.HREADY) state <= ST_ADDR;
                ST_ADDR: if (bus.HREADY) state <= ST_DATA;
                ST_DATA: if (bus.HREADY) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= bus.HRESP != HRESP_OKAY;
                    bus.resp_rdata <= (!write_q && bus.HRESP == HRESP_OKAY) ? bus.HRDATA : '0;
                    state          <= ST_IDLE;
                end else if (bus.HRESP == HRESP_ERROR) begin
                    state <= ST_RESP2;
                end else if (bus.HRESP == HRESP_RETRY || bus.HRESP == HRESP_SPLIT) begin
                    // re-issue the same captured command until the budget is spent
                    if (retry_cnt < MAX_CNT) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= ST_REQ;
                    end else begin
                        state <= ST_RESP2;
                    end
                end
                ST_RESP2: if (bus.HREADY) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b1;
                    bus.resp_rdata <= '0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    assign bus.req_ready = state == ST_IDLE;
    assign bus.HBUSREQ   = state == ST_REQ;
    assign bus.HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HLOCK     = lock_q && state != ST_IDLE;
    assign bus.HADDR     = addr_q;
    assign bus.HWRITE    = write_q;
    assign bus.HSIZE     = size_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HWDATA    = wdata_q;
endmodule
